phy_mdio_init: RTL and testbench

Power-up sequencer for the RGMII Ethernet PHY. It holds the PHY in hardware reset, releases it, waits for it to settle, then issues a fixed list of Clause-22 MDIO register writes on a write-only MDC/MDIO pair. It then asserts phy_init_done, which gates the Ethernet core's reset in top-level logic. It sits between the PLL-derived reset logic and the PHY pins, in the system clock domain.

---
 rtl/phy_mdio_init.sv | 151 +++++++++++++++
 tb/tb_phy_mdio_init.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_mdio_init.sv
// PHY power-up sequencer: holds the PHY in hardware reset, waits for it to settle,
// then issues a fixed table of Clause-22 MDIO writes before flagging init done.
module phy_mdio_init #(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned RESET_HOLD = 1250000,
    parameter int unsigned RESET_WAIT = 2500000,
    parameter logic [4:0]  PHY_ADDR   = 5'd0,
    parameter int unsigned NUM_WRITES = 2,
    parameter logic [4:0]  INIT_REG0  = 5'd0,
    parameter logic [15:0] INIT_DATA0 = 16'h1140,
    parameter logic [4:0]  INIT_REG1  = 5'd4,
    parameter logic [15:0] INIT_DATA1 = 16'h01E1
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic phy_resetn,
    output logic mdio_scl,
    output logic mdio_sda,
    output logic phy_init_done,
    output logic busy
);

    localparam int unsigned PERIOD  = 2 * CLK_DIV;
    localparam int unsigned MAX_HW  = (RESET_HOLD > RESET_WAIT) ? RESET_HOLD : RESET_WAIT;
    localparam int unsigned MAX_CNT = (MAX_HW > PERIOD) ? MAX_HW : PERIOD;
    localparam int unsigned CW      = $clog2(MAX_CNT);
    localparam int unsigned IW      = 2;

    // Preamble, ST=01, OP=01 (write), PHY address, register, TA=10, data
    localparam logic [63:0] FRAME0 = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, INIT_REG0, 2'b10, INIT_DATA0};
    localparam logic [63:0] FRAME1 = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, INIT_REG1, 2'b10, INIT_DATA1};

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [5:0]    bit_q, bit_n;
    logic [IW-1:0] idx_q, idx_n;
    logic [63:0]   shreg_q, shreg_n;
    logic          resetn_n, scl_n, sda_n, done_n, busy_n;

    // State, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            bit_q         <= '0;
            idx_q         <= '0;
            shreg_q       <= '0;
            phy_resetn    <= 1'b0;
            mdio_scl      <= 1'b0;
            mdio_sda      <= 1'b1;
            phy_init_done <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            bit_q         <= bit_n;
            idx_q         <= idx_n;
            shreg_q       <= shreg_n;
            phy_resetn    <= resetn_n;
            mdio_scl      <= scl_n;
            mdio_sda      <= sda_n;
            phy_init_done <= done_n;
            busy          <= busy_n;
        end
    end

    // Next state; outputs are derived from the next register values so they align with the state
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        idx_n   = idx_q;
        shreg_n = shreg_q;

        case (state_q)
            S_HOLD: begin
                if (cnt_q == CW'(RESET_HOLD - 1)) begin
                    cnt_n   = '0;
                    state_n = S_WAIT;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(RESET_WAIT - 1)) begin
                    cnt_n   = '0;
                    state_n = (NUM_WRITES > 0) ? S_LOAD : S_DONE;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                shreg_n = (idx_q == '0) ? FRAME0 : FRAME1;
                cnt_n   = '0;
                bit_n   = '0;
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CW'(PERIOD - 1)) begin
                    cnt_n = '0;
                    if (bit_q == 6'd63) begin
                        state_n = S_GAP;
                    end else begin
                        bit_n   = bit_q + 6'd1;
                        shreg_n = {shreg_q[62:0], 1'b1};
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(PERIOD - 1)) begin
                    cnt_n   = '0;
                    idx_n   = idx_q + IW'(1);
                    state_n = ((idx_q + IW'(1)) == IW'(NUM_WRITES)) ? S_DONE : S_LOAD;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (restart) begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            default: begin
                state_n = S_HOLD;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        resetn_n = (state_n != S_HOLD);
        scl_n    = (state_n == S_SHIFT) && (cnt_n >= CW'(CLK_DIV));
        sda_n    = (state_n == S_SHIFT) ? shreg_n[63] : 1'b1;
        done_n   = (state_n == S_DONE);
        busy_n   = (state_n != S_DONE);
    end

endmodule

// File: tb/tb_phy_mdio_init.sv
// Bench for phy_mdio_init: directed vector table, frame decode, reset/restart corner
// cases, and a randomized reset/restart run against a timeline-based reference model.
module tb_phy_mdio_init;

    localparam int D      = 2;
    localparam int H      = 8;
    localparam int W      = 4;
    localparam int N      = 2;
    localparam int FLEN   = 1 + 130 * D;
    localparam int DONE_T = H + W + N * FLEN;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic restart = 1'b0;
    logic restart0 = 1'b0;

    logic phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy;
    logic resetn0, scl0, sda0, done0, busy0;

    int checks = 0;
    int errors = 0;
    int t = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    phy_mdio_init #(
        .CLK_DIV(D), .RESET_HOLD(H), .RESET_WAIT(W), .PHY_ADDR(5'd0), .NUM_WRITES(N),
        .INIT_REG0(5'd0), .INIT_DATA0(16'h1140), .INIT_REG1(5'd4), .INIT_DATA1(16'h01E1)
    ) dut (
        .clock(clock), .reset(reset), .restart(restart),
        .phy_resetn(phy_resetn), .mdio_scl(mdio_scl), .mdio_sda(mdio_sda),
        .phy_init_done(phy_init_done), .busy(busy)
    );

    phy_mdio_init #(
        .CLK_DIV(D), .RESET_HOLD(H), .RESET_WAIT(W), .PHY_ADDR(5'd0), .NUM_WRITES(0),
        .INIT_REG0(5'd0), .INIT_DATA0(16'h1140), .INIT_REG1(5'd4), .INIT_DATA1(16'h01E1)
    ) dut0 (
        .clock(clock), .reset(reset), .restart(restart0),
        .phy_resetn(resetn0), .mdio_scl(scl0), .mdio_sda(sda0),
        .phy_init_done(done0), .busy(busy0)
    );

    function automatic logic [63:0] frame_of(int f);
        logic [4:0]  r;
        logic [15:0] d;
        r = (f == 0) ? 5'd0 : 5'd4;
        d = (f == 0) ? 16'h1140 : 16'h01E1;
        return {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd0, r, 2'b10, d};
    endfunction

    // Expected {resetn, scl, sda, done, busy} for cycle tt of a sequence
    function automatic logic [4:0] model_out(int tt);
        logic [4:0]  o;
        logic [63:0] fr;
        int u, f, r, s;
        o = 5'b00101;
        if (tt < H) return o;
        o[4] = 1'b1;
        if (tt < H + W) return o;
        u = tt - H - W;
        f = u / FLEN;
        r = u % FLEN;
        if (f >= N) return 5'b10110;
        if (r >= 1 && (r - 1) < 128 * D) begin
            s    = r - 1;
            fr   = frame_of(f);
            o[3] = ((s % (2 * D)) >= D);
            o[2] = fr[63 - s / (2 * D)];
        end
        return o;
    endfunction

    always @(posedge clock) begin
        if (reset) t <= 0;
        else if (t >= DONE_T) begin
            if (restart) t <= 0;
        end else t <= t + 1;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            checks++;
            if ({phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy} !== model_out(t)) begin
                errors++;
                $display("FAIL model t=%0d got=%b exp=%b", t,
                         {phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy}, model_out(t));
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic measure_done(output int n);
        n = 0;
        while (!phy_init_done && n < 2000) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        int         cyc;
        logic [4:0] o;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic [63:0] cap[2];
        int nbits, hi_run, bad_width, done_first, rn_first, scl_first;
        int done0_first, scl0_hi, sda0_lo, n, n_low;
        logic prev_scl;

        vt[0]  = '{0,   5'b00101};
        vt[1]  = '{7,   5'b00101};
        vt[2]  = '{8,   5'b10101};
        vt[3]  = '{11,  5'b10101};
        vt[4]  = '{12,  5'b10101};
        vt[5]  = '{13,  5'b10101};
        vt[6]  = '{14,  5'b10101};
        vt[7]  = '{15,  5'b11101};
        vt[8]  = '{141, 5'b10001};
        vt[9]  = '{143, 5'b11001};
        vt[10] = '{145, 5'b10101};
        vt[11] = '{267, 5'b11001};
        vt[12] = '{270, 5'b10101};
        vt[13] = '{273, 5'b10101};
        vt[14] = '{533, 5'b10101};
        vt[15] = '{534, 5'b10110};

        // Nominal run: cycle 0 is the first cycle with reset low
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        nbits = 0; hi_run = 0; bad_width = 0; prev_scl = 1'b0;
        done_first = -1; rn_first = -1; scl_first = -1;
        done0_first = -1; scl0_hi = 0; sda0_lo = 0;
        cap[0] = '0; cap[1] = '0;
        for (int c = 0; c <= DONE_T + 5; c++) begin
            for (int k = 0; k < 16; k++) begin
                if (vt[k].cyc == c)
                    check($sformatf("vec_c%0d", c), 64'({phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy}),
                          64'(vt[k].o));
            end
            if (mdio_scl && !prev_scl) begin
                if (nbits < 128) cap[nbits / 64] = {cap[nbits / 64][62:0], mdio_sda};
                nbits++;
            end
            if (mdio_scl) hi_run++;
            else if (prev_scl) begin
                if (hi_run != 2) bad_width++;
                hi_run = 0;
            end
            prev_scl = mdio_scl;
            if (phy_init_done && done_first < 0) done_first = c;
            if (phy_resetn && rn_first < 0) rn_first = c;
            if (mdio_scl && scl_first < 0) scl_first = c;
            if (done0 && done0_first < 0) done0_first = c;
            if (scl0) scl0_hi++;
            if (!sda0) sda0_lo++;
            @(negedge clock);
        end
        check("frame0", cap[0], 64'hFFFFFFFF_5002_1140);
        check("frame1", cap[1], 64'hFFFFFFFF_5012_01E1);
        check("mdc_pulses", 64'(nbits), 64'd128);
        check("mdc_high_width", 64'(bad_width), 64'd0);
        check("resetn_rise", 64'(rn_first), 64'd8);
        check("first_mdc_high", 64'(scl_first), 64'd15);
        check("done_rise", 64'(done_first), 64'd534);
        check("busy_low", 64'(busy), 64'd0);
        check("nw0_done_rise", 64'(done0_first), 64'd12);
        check("nw0_scl_activity", 64'(scl0_hi), 64'd0);
        check("nw0_sda_low", 64'(sda0_lo), 64'd0);

        // Reset mid-frame at cycle 100
        reset_pulse();
        repeat (100) @(negedge clock);
        reset_pulse();
        check("midreset_outs", 64'({phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy}), 64'(5'b00101));
        measure_done(n);
        check("midreset_done", 64'(n), 64'(DONE_T));

        // Restart in DONE
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        check("restart_done_low", 64'(phy_init_done), 64'd0);
        check("restart_resetn_low", 64'(phy_resetn), 64'd0);
        n_low = 0;
        while (!phy_resetn && n_low < 100) begin
            @(negedge clock);
            n_low++;
        end
        check("restart_hold_len", 64'(n_low), 64'(H));
        measure_done(n);
        check("restart_done", 64'(n_low + n), 64'(DONE_T));

        // Restart during SHIFT is ignored
        reset_pulse();
        repeat (50) @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        measure_done(n);
        check("restart_in_shift", 64'(51 + n), 64'(DONE_T));

        // Reset and restart together in DONE: reset wins
        reset   = 1'b1;
        restart = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        restart = 1'b0;
        check("rst_rs_outs", 64'({phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy}), 64'(5'b00101));
        measure_done(n);
        check("rst_rs_done", 64'(n), 64'(DONE_T));

        // Randomized reset/restart, checked cycle by cycle against the model
        for (int i = 0; i < 20000; i++) begin
            reset   = ($urandom_range(0, 1499) == 0);
            restart = phy_init_done ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 99) == 0);
            @(negedge clock);
        end
        reset   = 1'b0;
        restart = 1'b0;
        @(negedge clock);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
